// File: rtl/gmii_tx_scheduler.sv
// rtl/gmii_tx_scheduler.sv - round-robin GMII transmit scheduler with preamble, abort and IFG handling
//
// Shares one GMII TX interface between NUM_REQ frame sources. Arbitration is
// round-robin on frame boundaries. Each granted frame gets preamble + SFD, its
// payload streamed through valid/ready, TxER on underrun/oversize, and a
// forced inter-frame gap.
//
// Ports:
//   i_TxClk       GMII transmit clock (rising edge)
//   i_Reset       synchronous reset, active-high
//   iv_Req        per-requester frame pending
//   iv_Data       payload byte of lane k on [8k+7:8k]
//   iv_Valid      per-lane byte valid
//   iv_Last       per-lane final byte of frame
//   ov_Ready      combinational; grant & (state == DATA)
//   ov_Grant      registered one-hot grant
//   o8_TxD        GMII TXD (registered)
//   o_TxEN        GMII TX_EN (registered)
//   o_TxER        GMII TX_ER (registered)
//   o16_FrameCnt  frames completed normally (wraps)
//   o16_AbortCnt  frames aborted by underrun or oversize (wraps)

module gmii_tx_scheduler #(
  parameter int NUM_REQ    = 2,
  parameter int IFG_CYCLES = 12,
  parameter int MAX_BYTES  = 1522
) (
  input  logic                   i_TxClk,
  input  logic                   i_Reset,
  input  logic [NUM_REQ-1:0]     iv_Req,
  input  logic [8*NUM_REQ-1:0]   iv_Data,
  input  logic [NUM_REQ-1:0]     iv_Valid,
  input  logic [NUM_REQ-1:0]     iv_Last,
  output logic [NUM_REQ-1:0]     ov_Ready,
  output logic [NUM_REQ-1:0]     ov_Grant,
  output logic [7:0]             o8_TxD,
  output logic                   o_TxEN,
  output logic                   o_TxER,
  output logic [15:0]            o16_FrameCnt,
  output logic [15:0]            o16_AbortCnt
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(MAX_BYTES + 1);
  localparam int IW = $clog2(IFG_CYCLES + 1);
  localparam logic [CW-1:0] MAX_C   = CW'(MAX_BYTES);
  localparam logic [IW-1:0] IFG_C   = IW'(IFG_CYCLES);
  localparam logic [PW-1:0] PTR_RST = PW'(NUM_REQ - 1);

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_IFG} state_e;

  state_e               state_q, state_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [7:0]           txd_q, txd_d;
  logic                 txen_q, txen_d;
  logic                 txer_q, txer_d;
  logic [15:0]          frame_cnt_q, frame_cnt_d;
  logic [15:0]          abort_cnt_q, abort_cnt_d;
  logic [CW-1:0]        byte_cnt_q, byte_cnt_d;
  logic [2:0]           pre_cnt_q, pre_cnt_d;
  logic [IW-1:0]        ifg_cnt_q, ifg_cnt_d;

  logic                 win_found;
  logic [PW-1:0]        win_idx;
  logic                 valid_sel;
  logic                 last_sel;
  logic [7:0]           data_sel;

  // Round-robin pick: lowest requester above the pointer wins; if none, wrap
  // to the lowest requester overall (which may be the pointer itself).
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (iv_Req[k]) begin
        win_found = 1'b1;
        win_idx   = PW'(k);
      end
    end
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (iv_Req[k] && (PW'(k) > ptr_q)) begin
        win_idx = PW'(k);
      end
    end
  end

  // ptr_q holds the current winner while a frame is in flight.
  assign valid_sel = iv_Valid[ptr_q];
  assign last_sel  = iv_Last[ptr_q];
  assign data_sel  = iv_Data[{ptr_q, 3'b000} +: 8];

  assign ov_Ready     = (state_q == S_DATA) ? grant_q : '0;
  assign ov_Grant     = grant_q;
  assign o8_TxD       = txd_q;
  assign o_TxEN       = txen_q;
  assign o_TxER       = txer_q;
  assign o16_FrameCnt = frame_cnt_q;
  assign o16_AbortCnt = abort_cnt_q;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    txd_d       = txd_q;
    txen_d      = txen_q;
    txer_d      = txer_q;
    frame_cnt_d = frame_cnt_q;
    abort_cnt_d = abort_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    pre_cnt_d   = pre_cnt_q;
    ifg_cnt_d   = ifg_cnt_q;

    case (state_q)
      S_IDLE: begin
        txen_d = 1'b0;
        txer_d = 1'b0;
        txd_d  = 8'h00;
        if (win_found) begin
          state_d          = S_PRE;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          ptr_d            = win_idx;
          txen_d           = 1'b1;
          txd_d            = 8'h55;
          byte_cnt_d       = '0;
          pre_cnt_d        = 3'd1;
        end
      end

      // The IDLE edge already drove the first 0x55; six more follow, then SFD.
      S_PRE: begin
        txen_d = 1'b1;
        txer_d = 1'b0;
        if (pre_cnt_q != 3'd7) begin
          txd_d     = 8'h55;
          pre_cnt_d = pre_cnt_q + 3'd1;
        end else begin
          txd_d   = 8'hD5;
          state_d = S_DATA;
        end
      end

      // Underrun and the byte past MAX_BYTES both end in a single TxER cycle.
      S_DATA: begin
        txen_d = 1'b1;
        if (valid_sel && (byte_cnt_q != MAX_C)) begin
          txd_d      = data_sel;
          txer_d     = 1'b0;
          byte_cnt_d = byte_cnt_q + CW'(1);
          if (last_sel) begin
            state_d     = S_IFG;
            grant_d     = '0;
            ifg_cnt_d   = '0;
            frame_cnt_d = frame_cnt_q + 16'd1;
          end
        end else begin
          txd_d       = 8'h00;
          txer_d      = 1'b1;
          state_d     = S_IFG;
          grant_d     = '0;
          ifg_cnt_d   = '0;
          abort_cnt_d = abort_cnt_q + 16'd1;
        end
      end

      // Counting from 0 to IFG_CYCLES spans IFG_CYCLES idle cycles on the wire,
      // because the first IFG cycle still shows the final byte.
      S_IFG: begin
        txen_d  = 1'b0;
        txer_d  = 1'b0;
        txd_d   = 8'h00;
        grant_d = '0;
        if (ifg_cnt_q == IFG_C) begin
          state_d = S_IDLE;
        end else begin
          ifg_cnt_d = ifg_cnt_q + IW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_TxClk) begin
    if (i_Reset) begin
      state_q     <= S_IDLE;
      ptr_q       <= PTR_RST;
      grant_q     <= '0;
      txd_q       <= 8'h00;
      txen_q      <= 1'b0;
      txer_q      <= 1'b0;
      frame_cnt_q <= 16'd0;
      abort_cnt_q <= 16'd0;
      byte_cnt_q  <= '0;
      pre_cnt_q   <= 3'd0;
      ifg_cnt_q   <= IFG_C;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      txd_q       <= txd_d;
      txen_q      <= txen_d;
      txer_q      <= txer_d;
      frame_cnt_q <= frame_cnt_d;
      abort_cnt_q <= abort_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      pre_cnt_q   <= pre_cnt_d;
      ifg_cnt_q   <= ifg_cnt_d;
    end
  end

endmodule

// File: tb/tb_gmii_tx_scheduler.sv
// tb/tb_gmii_tx_scheduler.sv - self-checking bench for gmii_tx_scheduler

module tb_gmii_tx_scheduler;

  localparam int NREQ = 2;
  localparam int IFGC = 12;
  localparam int MAXB = 64;

  logic              clk;
  logic              i_Reset;
  logic [NREQ-1:0]   iv_Req;
  logic [8*NREQ-1:0] iv_Data;
  logic [NREQ-1:0]   iv_Valid;
  logic [NREQ-1:0]   iv_Last;
  logic [NREQ-1:0]   ov_Ready;
  logic [NREQ-1:0]   ov_Grant;
  logic [7:0]        o8_TxD;
  logic              o_TxEN;
  logic              o_TxER;
  logic [15:0]       o16_FrameCnt;
  logic [15:0]       o16_AbortCnt;

  gmii_tx_scheduler #(.NUM_REQ(NREQ), .IFG_CYCLES(IFGC), .MAX_BYTES(MAXB)) dut (
    .i_TxClk     (clk),
    .i_Reset     (i_Reset),
    .iv_Req      (iv_Req),
    .iv_Data     (iv_Data),
    .iv_Valid    (iv_Valid),
    .iv_Last     (iv_Last),
    .ov_Ready    (ov_Ready),
    .ov_Grant    (ov_Grant),
    .o8_TxD      (o8_TxD),
    .o_TxEN      (o_TxEN),
    .o_TxER      (o_TxER),
    .o16_FrameCnt(o16_FrameCnt),
    .o16_AbortCnt(o16_AbortCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       er;
  } exp_t;

  exp_t sb[$];
  int   grant_log[$];
  int   gap_log[$];
  int   len_log[$];

  int pass_cnt  = 0;
  int check_cnt = 0;
  int exp_frames = 0;
  int exp_aborts = 0;

  // Wire monitor: preamble checked against constants, payload against scoreboard.
  initial begin
    bit   in_frame;
    int   pre_idx;
    int   flen;
    int   idle;
    exp_t e;
    logic [7:0] pb;
    in_frame = 0; pre_idx = 0; flen = 0; idle = 1000;
    forever begin
      @(posedge clk);
      #1;
      if (i_Reset) begin
        sb.delete();
        in_frame = 0;
        idle     = 1000;
      end else if (o_TxEN) begin
        if (!in_frame) begin
          in_frame = 1;
          pre_idx  = 0;
          flen     = 0;
          gap_log.push_back(idle);
          grant_log.push_back(ov_Grant == 2'b01 ? 0 : (ov_Grant == 2'b10 ? 1 : -1));
        end
        flen++;
        if (pre_idx < 8) begin
          pb = (pre_idx < 7) ? 8'h55 : 8'hD5;
          check_cnt++;
          if (o8_TxD !== pb || o_TxER !== 1'b0)
            $display("FAIL preamble[%0d] got TxD=%02h TxER=%b want TxD=%02h TxER=0", pre_idx, o8_TxD, o_TxER, pb);
          else pass_cnt++;
          pre_idx++;
        end else if (sb.size() == 0) begin
          check_cnt++;
          $display("FAIL unexpected_byte got TxD=%02h TxER=%b want no byte", o8_TxD, o_TxER);
        end else begin
          e = sb.pop_front();
          check_cnt++;
          if (o8_TxD !== e.d || o_TxER !== e.er)
            $display("FAIL payload got TxD=%02h TxER=%b want TxD=%02h TxER=%b", o8_TxD, o_TxER, e.d, e.er);
          else pass_cnt++;
        end
      end else begin
        if (in_frame) begin
          in_frame = 0;
          len_log.push_back(flen);
          idle = 0;
          check_cnt++;
          if (o_TxER !== 1'b0) $display("FAIL txer_idle got %b want 0", o_TxER);
          else pass_cnt++;
        end
        idle++;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "timeout");
  end

  // Source model for lane k: n-byte frame, valid dropped at stop_after,
  // optional reset assertion when payload byte reset_at is presented.
  task automatic src_frame(input int k, input int n, input int stop_after,
                           input int reset_at, input logic [7:0] base);
    int  idx   = 0;
    int  guard = 0;
    bit  seen  = 0;
    bit  ended = 0;
    logic [7:0] b;
    @(negedge clk);
    iv_Req[k] = 1'b1;
    while (!ended && guard < 3000) begin
      b = base + 8'(idx);
      iv_Data[8*k +: 8] = b;
      iv_Valid[k] = (idx < stop_after);
      iv_Last[k]  = (idx == n - 1);
      if (ov_Ready[k]) begin
        seen = 1;
        iv_Req[k] = 1'b0;
        if (reset_at >= 0 && idx == reset_at) begin
          i_Reset = 1'b1;
          ended   = 1;
        end else if (iv_Valid[k]) begin
          if (idx == MAXB) sb.push_back('{d: 8'h00, er: 1'b1});
          else             sb.push_back('{d: b, er: 1'b0});
          idx++;
        end else begin
          sb.push_back('{d: 8'h00, er: 1'b1});
        end
      end else if (seen) begin
        ended = 1;
      end
      if (!ended) begin
        @(negedge clk);
        guard++;
      end
    end
    iv_Valid[k] = 1'b0;
    iv_Last[k]  = 1'b0;
    iv_Req[k]   = 1'b0;
    check_cnt++;
    if (!ended) $display("FAIL src%0d_timeout got %0d cycles want frame end", k, guard);
    else pass_cnt++;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    i_Reset = 1'b1;
    repeat (3) @(negedge clk);
    i_Reset = 1'b0;
    exp_frames = 0;
    exp_aborts = 0;
  endtask

  task automatic clear_logs();
    grant_log.delete();
    gap_log.delete();
    len_log.delete();
  endtask

  task automatic drain();
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset();
    reset_dut();
    check_cnt++;
    if (o_TxEN !== 1'b0 || o_TxER !== 1'b0 || o8_TxD !== 8'h00)
      $display("FAIL reset_wire got EN=%b ER=%b D=%02h want 0/0/00", o_TxEN, o_TxER, o8_TxD);
    else pass_cnt++;
    check_cnt++;
    if (ov_Grant !== 2'b00 || ov_Ready !== 2'b00)
      $display("FAIL reset_grant got G=%b R=%b want 00/00", ov_Grant, ov_Ready);
    else pass_cnt++;
    check_cnt++;
    if (o16_FrameCnt !== 16'd0 || o16_AbortCnt !== 16'd0)
      $display("FAIL reset_counters got F=%0d A=%0d want 0/0", o16_FrameCnt, o16_AbortCnt);
    else pass_cnt++;
  endtask

  task automatic test_single_frame();
    clear_logs();
    src_frame(0, 60, 60, -1, 8'h00);
    exp_frames++;
    drain();
    check_cnt++;
    if (len_log.size() != 1 || len_log[0] != 68)
      $display("FAIL t1_len got n=%0d len=%0d want 1/68", len_log.size(), len_log.size() ? len_log[0] : -1);
    else pass_cnt++;
    check_cnt++;
    if (grant_log.size() != 1 || grant_log[0] != 0)
      $display("FAIL t1_grant got %0d want 0", grant_log.size() ? grant_log[0] : -1);
    else pass_cnt++;
    check_cnt++;
    if (o16_FrameCnt !== 16'(exp_frames) || o16_AbortCnt !== 16'(exp_aborts))
      $display("FAIL t1_counters got F=%0d A=%0d want %0d/%0d", o16_FrameCnt, o16_AbortCnt, exp_frames, exp_aborts);
    else pass_cnt++;
    check_cnt++;
    if (sb.size() != 0) $display("FAIL t1_sb_left got %0d want 0", sb.size());
    else pass_cnt++;
  endtask

  task automatic test_round_robin();
    int want_g[4] = '{0, 1, 0, 1};
    reset_dut();
    clear_logs();
    fork
      begin
        src_frame(0, 64, 64, -1, 8'h40);
        src_frame(0, 64, 64, -1, 8'h80);
      end
      begin
        src_frame(1, 64, 64, -1, 8'hA0);
        src_frame(1, 64, 64, -1, 8'hC0);
      end
    join
    exp_frames += 4;
    drain();
    check_cnt++;
    if (grant_log.size() != 4) $display("FAIL t2_nframes got %0d want 4", grant_log.size());
    else pass_cnt++;
    for (int i = 0; i < 4 && i < grant_log.size(); i++) begin
      check_cnt++;
      if (grant_log[i] != want_g[i]) $display("FAIL t2_grant[%0d] got %0d want %0d", i, grant_log[i], want_g[i]);
      else pass_cnt++;
      check_cnt++;
      if (len_log.size() <= i || len_log[i] != 72)
        $display("FAIL t2_len[%0d] got %0d want 72", i, len_log.size() > i ? len_log[i] : -1);
      else pass_cnt++;
    end
    for (int i = 1; i < 4 && i < gap_log.size(); i++) begin
      check_cnt++;
      if (gap_log[i] != IFGC + 1) $display("FAIL t2_gap[%0d] got %0d want %0d", i, gap_log[i], IFGC + 1);
      else pass_cnt++;
    end
    check_cnt++;
    if (o16_FrameCnt !== 16'(exp_frames)) $display("FAIL t2_framecnt got %0d want %0d", o16_FrameCnt, exp_frames);
    else pass_cnt++;
  endtask

  task automatic test_underrun();
    clear_logs();
    src_frame(1, 40, 20, -1, 8'h10);
    exp_aborts++;
    drain();
    check_cnt++;
    if (len_log.size() != 1 || len_log[0] != 8 + 21)
      $display("FAIL t3_len got %0d want 29", len_log.size() ? len_log[0] : -1);
    else pass_cnt++;
    check_cnt++;
    if (o16_AbortCnt !== 16'(exp_aborts) || o16_FrameCnt !== 16'(exp_frames))
      $display("FAIL t3_counters got F=%0d A=%0d want %0d/%0d", o16_FrameCnt, o16_AbortCnt, exp_frames, exp_aborts);
    else pass_cnt++;
  endtask

  task automatic test_oversize();
    clear_logs();
    src_frame(0, 70, 70, -1, 8'h20);
    exp_aborts++;
    drain();
    check_cnt++;
    if (len_log.size() != 1 || len_log[0] != 8 + MAXB + 1)
      $display("FAIL t4_over_len got %0d want %0d", len_log.size() ? len_log[0] : -1, 8 + MAXB + 1);
    else pass_cnt++;
    check_cnt++;
    if (o16_AbortCnt !== 16'(exp_aborts) || o16_FrameCnt !== 16'(exp_frames))
      $display("FAIL t4_over_counters got F=%0d A=%0d want %0d/%0d", o16_FrameCnt, o16_AbortCnt, exp_frames, exp_aborts);
    else pass_cnt++;
    clear_logs();
    src_frame(1, MAXB, MAXB, -1, 8'h60);
    exp_frames++;
    drain();
    check_cnt++;
    if (len_log.size() != 1 || len_log[0] != 8 + MAXB)
      $display("FAIL t4_exact_len got %0d want %0d", len_log.size() ? len_log[0] : -1, 8 + MAXB);
    else pass_cnt++;
    check_cnt++;
    if (o16_AbortCnt !== 16'(exp_aborts) || o16_FrameCnt !== 16'(exp_frames))
      $display("FAIL t4_exact_counters got F=%0d A=%0d want %0d/%0d", o16_FrameCnt, o16_AbortCnt, exp_frames, exp_aborts);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_frame();
    clear_logs();
    src_frame(0, 60, 60, 10, 8'h00);
    @(negedge clk);
    check_cnt++;
    if (o_TxEN !== 1'b0 || ov_Grant !== 2'b00)
      $display("FAIL t5_after_reset got EN=%b G=%b want 0/00", o_TxEN, ov_Grant);
    else pass_cnt++;
    check_cnt++;
    if (o16_FrameCnt !== 16'd0 || o16_AbortCnt !== 16'd0)
      $display("FAIL t5_counters got F=%0d A=%0d want 0/0", o16_FrameCnt, o16_AbortCnt);
    else pass_cnt++;
    i_Reset = 1'b0;
    exp_frames = 0;
    exp_aborts = 0;
    clear_logs();
    fork
      src_frame(1, 16, 16, -1, 8'h70);
      src_frame(0, 16, 16, -1, 8'h30);
    join
    exp_frames += 2;
    drain();
    check_cnt++;
    if (grant_log.size() != 2 || grant_log[0] != 0 || grant_log[1] != 1)
      $display("FAIL t5_order got n=%0d first=%0d want 2 frames 0,1", grant_log.size(), grant_log.size() ? grant_log[0] : -1);
    else pass_cnt++;
    check_cnt++;
    if (o16_FrameCnt !== 16'(exp_frames)) $display("FAIL t5_framecnt got %0d want %0d", o16_FrameCnt, exp_frames);
    else pass_cnt++;
  endtask

  initial begin
    i_Reset  = 1'b1;
    iv_Req   = '0;
    iv_Data  = '0;
    iv_Valid = '0;
    iv_Last  = '0;
    test_reset();
    test_single_frame();
    test_round_robin();
    test_underrun();
    test_oversize();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
